data_mem_controller: RTL and testbench

DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

---
 rtl/rv32im_mem_defs.sv | 32 +++
 rtl/data_mem_controller_if.sv | 30 +++
 rtl/load_store_align.sv | 57 +++++
 rtl/data_mem_controller.sv | 82 ++++++++
 tb/tb_data_mem_controller.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rv32im_mem_defs.sv
// Shared memory-operation codes and controller state encodings, used by the
// control unit and the data memory controller.
package rv32im_mem_defs;

    localparam logic [3:0] RW_LB  = 4'b1000;
    localparam logic [3:0] RW_LH  = 4'b1001;
    localparam logic [3:0] RW_LW  = 4'b1010;
    localparam logic [3:0] RW_SB  = 4'b1011;
    localparam logic [3:0] RW_LBU = 4'b1100;
    localparam logic [3:0] RW_LHU = 4'b1101;
    localparam logic [3:0] RW_SH  = 4'b1110;
    localparam logic [3:0] RW_SW  = 4'b1111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic is_store(input logic [3:0] code);
        return (code == RW_SB) || (code == RW_SH) || (code == RW_SW);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_misaligned(input logic [3:0] code, input logic [1:0] addr_lo);
        case (code)
            RW_LH, RW_LHU, RW_SH: return addr_lo[0];
            RW_LW, RW_SW:         return |addr_lo;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_controller_if.sv
// CPU-side and memory-side signals of the data memory controller, bundled.
// master = the controller, slave = the pipeline/memory environment around it.
interface data_mem_controller_if;
    logic [3:0]  READ_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [1:0]  DBG_STATE;

    modport master (
        input  READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
        output READ_DATA, BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE,
               MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN, DBG_STATE
    );

    modport slave (
        output READ_WRITE, ADDRESS, WRITE_DATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READ_DATA, BUSYWAIT, MISALIGNED, MEM_READ, MEM_WRITE,
               MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN, DBG_STATE
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational lane selection: sign/zero extension for loads, lane
// replication and byte enables for stores.
module load_store_align
    import rv32im_mem_defs::*;
(
    input  logic [3:0]  i_code,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic [3:0]  o_byte_en
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            2'd3:    w_byte = i_load_word[31:24];
            default: w_byte = i_load_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

        o_load_data = i_load_word;
        case (i_code)
            RW_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            RW_LBU:  o_load_data = {24'd0, w_byte};
            RW_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            RW_LHU:  o_load_data = {16'd0, w_half};
            default: o_load_data = i_load_word;
        endcase

        o_store_word = i_store_data;
        o_byte_en    = 4'b0000;
        case (i_code)
            RW_SB: begin
                o_store_word = {4{i_store_data[7:0]}};
                o_byte_en    = 4'b0001 << i_addr_lo;
            end
            RW_SH: begin
                o_store_word = {2{i_store_data[15:0]}};
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            RW_SW: begin
                o_store_word = i_store_data;
                o_byte_en    = 4'b1111;
            end
            default: begin
                o_store_word = i_store_data;
                o_byte_en    = 4'b0000;
            end
        endcase
    end
endmodule

// File: rtl/data_mem_controller.sv
// Data memory controller: IDLE -> READ/WRITE -> DONE access FSM between the
// pipeline and a word-addressed memory with a busywait handshake.
module data_mem_controller
    import rv32im_mem_defs::*;
(
    input logic                  CLK,
    input logic                  RESET_N,
    data_mem_controller_if.master bus
);
    // Handshake: BUSYWAIT is high from the request cycle until the access
    // completes; MEM_READ/MEM_WRITE stay high with stable address/data until
    // MEM_BUSYWAIT is seen low at a rising edge, and the next cycle is DONE.
    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_code;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;
    logic        w_req;
    logic        w_misaligned;
    logic        w_accept;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;
    logic [3:0]  w_byte_en;

    assign w_req        = (r_state == ST_IDLE) && bus.READ_WRITE[3];
    assign w_misaligned = w_req && is_misaligned(bus.READ_WRITE, bus.ADDRESS[1:0]);
    assign w_accept     = w_req && !w_misaligned;

    load_store_align u_align (
        .i_code       (r_code),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_wdata),
        .i_load_word  (bus.MEM_READDATA),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_byte_en    (w_byte_en)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = is_store(bus.READ_WRITE) ? ST_WRITE : ST_READ;
            ST_READ,
            ST_WRITE: if (!bus.MEM_BUSYWAIT) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_code      <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_code  <= bus.READ_WRITE;
                r_addr  <= bus.ADDRESS;
                r_wdata <= bus.WRITE_DATA;
            end
            if (w_misaligned)
                r_read_data <= 32'd0;
            else if ((r_state == ST_READ) && !bus.MEM_BUSYWAIT)
                r_read_data <= w_load_data;
        end
    end

    // Request-cycle outputs are combinational, so gate them with reset too.
    assign bus.BUSYWAIT      = RESET_N && (w_accept || (r_state == ST_READ) || (r_state == ST_WRITE));
    assign bus.MISALIGNED    = RESET_N && w_misaligned;
    assign bus.MEM_READ      = (r_state == ST_READ);
    assign bus.MEM_WRITE     = (r_state == ST_WRITE);
    assign bus.MEM_ADDRESS   = {r_addr[31:2], 2'b00};
    assign bus.MEM_WRITEDATA = w_store_word;
    assign bus.MEM_BYTE_EN   = (r_state == ST_WRITE) ? w_byte_en : 4'b0000;
    assign bus.READ_DATA     = bus.MISALIGNED ? 32'd0 : r_read_data;
    assign bus.DBG_STATE     = r_state;
endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: aligned loads/stores, lane
// formatting, busywait stretching, misalignment and mid-access reset.
module tb_data_mem_controller;
    import rv32im_mem_defs::*;

    logic CLK;
    logic RESET_N;
    int   checks;
    int   failures;

    data_mem_controller_if bus ();

    data_mem_controller dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [3:0] code, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic mbusy);
        bus.READ_WRITE   = code;
        bus.ADDRESS      = addr;
        bus.WRITE_DATA   = wdata;
        bus.MEM_READDATA = rdata;
        bus.MEM_BUSYWAIT = mbusy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET_N  = 1'b0;
        request(4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);

        // Reset state
        #3;
        chk1("rst_busywait", bus.BUSYWAIT, 1'b0);
        chk1("rst_mem_read", bus.MEM_READ, 1'b0);
        chk ("rst_read_data", bus.READ_DATA, 32'd0);
        chk ("rst_mem_addr", bus.MEM_ADDRESS, 32'd0);
        chk ("rst_byte_en", {28'd0, bus.MEM_BYTE_EN}, 32'd0);
        chk ("rst_state", {30'd0, bus.DBG_STATE}, {30'd0, ST_IDLE});
        #9 RESET_N = 1'b1;
        step();

        // LW 0x10, memory answers at once
        request(RW_LW, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        #2 chk1("lw_c0_busywait", bus.BUSYWAIT, 1'b1);
        chk1("lw_c0_misaligned", bus.MISALIGNED, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk1("lw_c1_busywait", bus.BUSYWAIT, 1'b1);
        chk1("lw_c1_mem_read", bus.MEM_READ, 1'b1);
        chk ("lw_c1_mem_addr", bus.MEM_ADDRESS, 32'h0000_0010);
        chk ("lw_c1_byte_en", {28'd0, bus.MEM_BYTE_EN}, 32'd0);
        step();
        #2 chk1("lw_c2_busywait", bus.BUSYWAIT, 1'b0);
        chk1("lw_c2_mem_read", bus.MEM_READ, 1'b0);
        chk ("lw_c2_read_data", bus.READ_DATA, 32'hDEAD_BEEF);
        chk ("lw_c2_state", {30'd0, bus.DBG_STATE}, {30'd0, ST_DONE});
        step();
        #2 chk("lw_hold_read_data", bus.READ_DATA, 32'hDEAD_BEEF);
        chk ("lw_back_idle", {30'd0, bus.DBG_STATE}, {30'd0, ST_IDLE});

        // LB / LBU at 0x13, lane 3 = 0x80
        request(RW_LB, 32'h0000_0013, 32'd0, 32'h80FF_0000, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        step();
        #2 chk("lb_read_data", bus.READ_DATA, 32'hFFFF_FF80);
        step();
        request(RW_LBU, 32'h0000_0013, 32'd0, 32'h80FF_0000, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        step();
        #2 chk("lbu_read_data", bus.READ_DATA, 32'h0000_0080);
        step();

        // LH at 0x02, upper halfword negative
        request(RW_LH, 32'h0000_0002, 32'd0, 32'h8001_1234, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        step();
        #2 chk("lh_read_data", bus.READ_DATA, 32'hFFFF_8001);
        step();

        // SH at 0x22 with memory busy for 4 cycles; inputs scrambled meanwhile
        request(RW_SH, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 1'b1);
        #2 chk1("sh_c0_busywait", bus.BUSYWAIT, 1'b1);
        step();
        bus.READ_WRITE = RW_SB;
        bus.WRITE_DATA = 32'h5555_5555;
        bus.ADDRESS    = 32'h0000_0041;
        for (int k = 1; k <= 5; k++) begin
            #2;
            chk1($sformatf("sh_w%0d_mem_write", k), bus.MEM_WRITE, 1'b1);
            chk1($sformatf("sh_w%0d_busywait", k), bus.BUSYWAIT, 1'b1);
            chk ($sformatf("sh_w%0d_wdata", k), bus.MEM_WRITEDATA, 32'hABCD_ABCD);
            chk ($sformatf("sh_w%0d_byte_en", k), {28'd0, bus.MEM_BYTE_EN}, 32'h0000_000C);
            chk ($sformatf("sh_w%0d_addr", k), bus.MEM_ADDRESS, 32'h0000_0020);
            if (k == 5) bus.MEM_BUSYWAIT = 1'b0;
            step();
        end
        bus.READ_WRITE = 4'b0000;
        #2 chk1("sh_done_busywait", bus.BUSYWAIT, 1'b0);
        chk1("sh_done_mem_write", bus.MEM_WRITE, 1'b0);
        chk ("sh_done_byte_en", {28'd0, bus.MEM_BYTE_EN}, 32'd0);
        step();

        // SB at 0x01 and SW at 0x04
        request(RW_SB, 32'h0000_0001, 32'hCAFE_F05A, 32'd0, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk("sb_wdata", bus.MEM_WRITEDATA, 32'h5A5A_5A5A);
        chk ("sb_byte_en", {28'd0, bus.MEM_BYTE_EN}, 32'h0000_0002);
        step();
        step();
        request(RW_SW, 32'h0000_0004, 32'h0BAD_F00D, 32'd0, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk("sw_wdata", bus.MEM_WRITEDATA, 32'h0BAD_F00D);
        chk ("sw_byte_en", {28'd0, bus.MEM_BYTE_EN}, 32'h0000_000F);
        chk ("sw_addr", bus.MEM_ADDRESS, 32'h0000_0004);
        step();
        step();

        // Misaligned SW at 0x06
        request(RW_SW, 32'h0000_0006, 32'h1111_2222, 32'd0, 1'b0);
        #2 chk1("mis_pulse", bus.MISALIGNED, 1'b1);
        chk1("mis_busywait", bus.BUSYWAIT, 1'b0);
        chk1("mis_mem_write", bus.MEM_WRITE, 1'b0);
        chk ("mis_read_data", bus.READ_DATA, 32'd0);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk1("mis_pulse_end", bus.MISALIGNED, 1'b0);
        chk1("mis_no_write", bus.MEM_WRITE, 1'b0);
        chk ("mis_state", {30'd0, bus.DBG_STATE}, {30'd0, ST_IDLE});
        chk ("mis_read_data_hold", bus.READ_DATA, 32'd0);
        step();

        // Reset in the middle of a READ
        request(RW_LW, 32'h0000_0040, 32'd0, 32'h1234_5678, 1'b1);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk1("rr_mem_read_before", bus.MEM_READ, 1'b1);
        #1 RESET_N = 1'b0;
        #1 chk1("rr_mem_read", bus.MEM_READ, 1'b0);
        chk1("rr_busywait", bus.BUSYWAIT, 1'b0);
        chk ("rr_mem_addr", bus.MEM_ADDRESS, 32'd0);
        chk ("rr_state", {30'd0, bus.DBG_STATE}, {30'd0, ST_IDLE});
        #1 RESET_N = 1'b1;
        request(RW_LHU, 32'h0000_0002, 32'd0, 32'hF00D_0000, 1'b0);
        step();
        bus.READ_WRITE = 4'b0000;
        #2 chk("rr_lhu_state", {30'd0, bus.DBG_STATE}, {30'd0, ST_READ});
        step();
        #2 chk("rr_lhu_read_data", bus.READ_DATA, 32'h0000_F00D);
        chk1("rr_lhu_busywait", bus.BUSYWAIT, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
